// File: rtl/video_timing_if.sv
// video_timing_if: composite raster timing outputs plus the burst enable they depend on.
interface video_timing_if;
    logic       burst_en;
    logic       sync_n;
    logic       color_burst;
    logic       active;
    logic [9:0] pixel_x;
    logic [8:0] line;
    logic       vblank;
    logic       frame_start;
    modport master (
        input  burst_en,
        output sync_n, color_burst, active, pixel_x, line, vblank, frame_start
    );
    modport slave (
        output burst_en,
        input  sync_n, color_burst, active, pixel_x, line, vblank, frame_start
    );
endinterface

// File: rtl/video_composite_timing.sv
// video_composite_timing: free-running 240p NTSC raster counters with registered sync/burst/active decode.
module video_composite_timing #(
    parameter int H_TOTAL        = 1588,
    parameter int H_SYNC         = 117,
    parameter int H_EQ           = 58,
    parameter int H_BURST_START  = 132,
    parameter int H_BURST_LEN    = 63,
    parameter int H_ACTIVE_START = 256,
    parameter int H_ACTIVE_LEN   = 1280,
    parameter int V_TOTAL        = 262,
    parameter int V_ACTIVE_START = 21,
    parameter int V_ACTIVE_LEN   = 240
) (
    input  logic              clk,
    input  logic              rst_n,
    video_timing_if.master    vid
);
    localparam logic [10:0] HT1 = 11'(H_TOTAL - 1);
    localparam logic [10:0] HS  = 11'(H_SYNC);
    localparam logic [10:0] HE  = 11'(H_EQ);
    localparam logic [10:0] HH  = 11'(H_TOTAL / 2);
    localparam logic [10:0] HHE = 11'(H_TOTAL / 2 + H_EQ);
    localparam logic [10:0] HVS = 11'(H_TOTAL / 2 - H_SYNC);
    localparam logic [10:0] HTS = 11'(H_TOTAL - H_SYNC);
    localparam logic [10:0] HBS = 11'(H_BURST_START);
    localparam logic [10:0] HBE = 11'(H_BURST_START + H_BURST_LEN);
    localparam logic [10:0] HAS = 11'(H_ACTIVE_START);
    localparam logic [10:0] HAE = 11'(H_ACTIVE_START + H_ACTIVE_LEN);
    localparam logic [8:0]  VT1 = 9'(V_TOTAL - 1);
    localparam logic [8:0]  VAS = 9'(V_ACTIVE_START);
    localparam logic [8:0]  VAE = 9'(V_ACTIVE_START + V_ACTIVE_LEN);

    logic [10:0] h_q, h_d;
    logic [8:0]  v_q, v_d, line_q, line_d;
    logic [9:0]  pixel_x_q, pixel_x_d;
    logic        sync_n_q, sync_n_d, color_burst_q, color_burst_d, active_q, active_d;
    logic        vblank_q, vblank_d, frame_start_q, frame_start_d;
    logic        eq_line, vs_line, v_act, sync_low;

    always_comb begin
        h_d           = (h_q == HT1) ? '0 : h_q + 11'd1;
        v_d           = (h_q != HT1) ? v_q : (v_q == VT1) ? '0 : v_q + 9'd1;
        eq_line       = (v_q <= 9'd2) || (v_q >= 9'd6 && v_q <= 9'd8);
        vs_line       = (v_q >= 9'd3) && (v_q <= 9'd5);
        v_act         = (v_q >= VAS) && (v_q < VAE);
        // Both vertical-interval line types place their second pulse at the half-line point.
        sync_low      = eq_line ? (h_q < HE || (h_q >= HH && h_q < HHE)) :
                        vs_line ? (h_q < HVS || (h_q >= HH && h_q < HTS)) :
                                  (h_q < HS);
        sync_n_d      = !sync_low;
        color_burst_d = vid.burst_en && !eq_line && !vs_line && h_q >= HBS && h_q < HBE;
        active_d      = v_act && h_q >= HAS && h_q < HAE;
        pixel_x_d     = active_d ? 10'((h_q - HAS) >> 1) : '0;
        line_d        = v_q;
        vblank_d      = !v_act;
        frame_start_d = (h_q == '0) && (v_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q           <= '0;
            v_q           <= '0;
            sync_n_q      <= 1'b1;
            color_burst_q <= 1'b0;
            active_q      <= 1'b0;
            pixel_x_q     <= '0;
            line_q        <= '0;
            vblank_q      <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            sync_n_q      <= sync_n_d;
            color_burst_q <= color_burst_d;
            active_q      <= active_d;
            pixel_x_q     <= pixel_x_d;
            line_q        <= line_d;
            vblank_q      <= vblank_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vid.sync_n      = sync_n_q;
    assign vid.color_burst = color_burst_q;
    assign vid.active      = active_q;
    assign vid.pixel_x     = pixel_x_q;
    assign vid.line        = line_q;
    assign vid.vblank      = vblank_q;
    assign vid.frame_start = frame_start_q;
endmodule
